spi_xip_ctrl: RTL

APB slave front-end that owns the single Wishbone port of the SPI master core (spi_top) and shares it between two paths. APB accesses inside the SPI master window pass straight through to the core's registers. APB reads inside the flash window run an XIP sequence: a single 64-bit SPI read command (0x03 + 24-bit address), after which the result returns as the APB read data. It sits between the APB crossbar and spi_top.

---
 rtl/spi_xip_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_xip_ctrl.sv
// APB front-end sharing the spi_top Wishbone port between register passthrough and XIP flash reads.
// Optional one-word read buffer for XIP hits: define SPI_XIP_LINEBUF_EN.
`timescale 1ns/1ps
module spi_xip_ctrl #(
  parameter logic [31:0] FLASH_BASE = 32'h30000000,
  parameter logic [31:0] FLASH_END  = 32'h3fffffff,
  parameter logic [31:0] SPI_BASE   = 32'h10001000,
  parameter logic [31:0] SPI_END    = 32'h10001fff,
  parameter logic [15:0] SPI_DIV    = 16'h0001,
  parameter logic [7:0]  FLASH_SS   = 8'h01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  input  logic [2:0]  in_pprot,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  localparam logic [3:0] S_IDLE  = 4'd0, S_PT   = 4'd1, S_TX1 = 4'd2, S_DIV = 4'd3,
                         S_SS    = 4'd4, S_GO   = 4'd5, S_POLL = 4'd6, S_RX = 4'd7,
                         S_SSOFF = 4'd8, S_RESP = 4'd9;

  logic [3:0]  r_state;
  logic        r_stb, r_we, r_err;
  logic [23:0] r_addr;
  logic [31:0] r_wdata, r_rdata;
  logic [3:0]  r_strb;

  logic w_acc, w_in_spi, w_in_flash, w_wb_state, w_lb_hit, w_pt_wr, w_fill;
  logic [31:0] w_lb_data;
  logic w_unused;

  assign w_unused   = ^in_pprot;
  assign w_acc      = (r_state == S_IDLE) && in_psel && in_penable;
  assign w_in_spi   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);
  assign w_in_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign w_wb_state = (r_state != S_IDLE) && (r_state <= S_SSOFF);
  assign w_pt_wr    = w_acc && w_in_spi && in_pwrite;
  assign w_fill     = (r_state == S_SSOFF) && r_stb && wb_ack_i && !wb_err_i;

`ifdef SPI_XIP_LINEBUF_EN
  logic        r_lb_vld;
  logic [21:0] r_lb_tag;
  logic [31:0] r_lb_data;
  assign w_lb_hit  = r_lb_vld && (r_lb_tag == in_paddr[23:2]);
  assign w_lb_data = r_lb_data;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lb_vld  <= 1'b0;
      r_lb_tag  <= '0;
      r_lb_data <= '0;
    end else if (w_pt_wr) begin
      r_lb_vld <= 1'b0;
    end else if (w_fill) begin
      r_lb_vld  <= 1'b1;
      r_lb_tag  <= r_addr[23:2];
      r_lb_data <= r_rdata;
    end
  end
`else
  assign w_lb_hit  = 1'b0;
  assign w_lb_data = 32'h0;
`endif

  // Wishbone request is a pure function of state and the latched APB request, so it stays stable until ack.
  always_comb begin
    wb_adr_o = 5'h00;
    wb_dat_o = 32'h0;
    wb_sel_o = 4'h0;
    wb_we_o  = 1'b0;
    case (r_state)
      S_PT:    begin wb_adr_o = r_addr[4:0]; wb_dat_o = r_wdata; wb_sel_o = r_strb; wb_we_o = r_we; end
      S_TX1:   begin wb_adr_o = 5'h04; wb_dat_o = {8'h03, r_addr}; wb_sel_o = 4'hf; wb_we_o = 1'b1; end
      S_DIV:   begin wb_adr_o = 5'h14; wb_dat_o = {16'h0, SPI_DIV}; wb_sel_o = 4'hf; wb_we_o = 1'b1; end
      S_SS:    begin wb_adr_o = 5'h18; wb_dat_o = {24'h0, FLASH_SS}; wb_sel_o = 4'hf; wb_we_o = 1'b1; end
      S_GO:    begin wb_adr_o = 5'h10; wb_dat_o = 32'h0000_0140; wb_sel_o = 4'hf; wb_we_o = 1'b1; end
      S_POLL:  begin wb_adr_o = 5'h10; wb_sel_o = 4'hf; end
      S_RX:    begin wb_adr_o = 5'h00; wb_sel_o = 4'hf; end
      S_SSOFF: begin wb_adr_o = 5'h18; wb_sel_o = 4'hf; wb_we_o = 1'b1; end
      default: ;
    endcase
  end

  assign wb_stb_o   = r_stb;
  assign wb_cyc_o   = r_stb;
  assign in_pready  = (r_state == S_RESP);
  assign in_prdata  = (r_state == S_RESP) ? r_rdata : 32'h0;
  assign in_pslverr = (r_state == S_RESP) && r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_strb  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_addr  <= in_paddr[23:0];
          r_wdata <= in_pwdata;
          r_strb  <= in_pstrb;
          r_we    <= in_pwrite;
          r_err   <= 1'b0;
          r_rdata <= 32'h0;
          if (w_in_spi) begin
            r_state <= S_PT;
            r_stb   <= 1'b1;
          end else if (w_in_flash && !in_pwrite) begin
            if (w_lb_hit) begin
              r_rdata <= w_lb_data;
              r_state <= S_RESP;
            end else begin
              r_state <= S_TX1;
              r_stb   <= 1'b1;
            end
          end else begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: if (!w_wb_state) begin
          r_state <= S_IDLE;
          r_stb   <= 1'b0;
        end else if (!r_stb) begin
          // Idle gap after every ack; also paces repeated busy polls.
          r_stb <= 1'b1;
        end else if (wb_err_i) begin
          r_stb   <= 1'b0;
          r_err   <= 1'b1;
          r_rdata <= 32'h0;
          r_state <= S_RESP;
        end else if (wb_ack_i) begin
          r_stb <= 1'b0;
          case (r_state)
            S_PT:    begin r_rdata <= wb_dat_i; r_state <= S_RESP; end
            S_TX1:   r_state <= S_DIV;
            S_DIV:   r_state <= S_SS;
            S_SS:    r_state <= S_GO;
            S_GO:    r_state <= S_POLL;
            S_POLL:  if (!wb_dat_i[8]) r_state <= S_RX;
            S_RX:    begin
              r_rdata <= {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]};
              r_state <= S_SSOFF;
            end
            default: r_state <= S_RESP;
          endcase
        end
      endcase
    end
  end
endmodule
